// File: rtl/vec_mag_pkg.sv
// Shared definitions for the vec_mag stream arbiter slice.
// Holds the default widths, the arbiter state type and the tid sizing helper.
package vec_mag_pkg;

    localparam int COORD_WIDTH_DEF = 8;
    localparam int BEAT_WIDTH_DEF  = 4 * COORD_WIDTH_DEF;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int beat_width(input int cw);
        return 4 * cw;
    endfunction

    function automatic int tid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_mag_axis_skid.sv
// Two-entry skid buffer carrying data, last and tid between the arbiter and the core.
// Input ready comes straight from a flop so the arbiter never sees a long ready path.
module vec_mag_axis_skid #(
    parameter int DW = 32,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic [TW-1:0] in_tid,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [TW-1:0] out_tid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          empty
);

    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          out_last_q;
    logic [TW-1:0] out_tid_q;
    logic          skid_valid_q;
    logic [DW-1:0] skid_data_q;
    logic          skid_last_q;
    logic [TW-1:0] skid_tid_q;
    logic          in_fire;

    assign in_ready  = ~skid_valid_q;
    assign in_fire   = in_valid & in_ready;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_tid   = out_tid_q;
    assign out_valid = out_valid_q;
    assign empty     = ~out_valid_q & ~skid_valid_q;

    // Refill the output stage from skid first, then from input; park input in skid on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_tid_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_tid_q   <= '0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                out_last_q   <= skid_last_q;
                out_tid_q    <= skid_tid_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_data_q <= in_data;
                    out_last_q <= in_last;
                    out_tid_q  <= in_tid;
                end
            end
        end else if (in_fire) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data;
            skid_last_q  <= in_last;
            skid_tid_q   <= in_tid;
        end
    end

endmodule

// File: rtl/vec_mag_stream_arb.sv
// Round-robin packet arbiter merging NUM_SRC AXI-Stream sources onto one vec_mag core.
// A grant is held for a whole packet; the decision costs one idle cycle per packet.
module vec_mag_stream_arb
    import vec_mag_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        enable_i,
    input  logic [NUM_SRC-1:0][beat_width(COORD_WIDTH)-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]                          s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                          s_axis_tlast,
    output logic [NUM_SRC-1:0]                          s_axis_tready,
    output logic [beat_width(COORD_WIDTH)-1:0]          m_axis_tdata,
    output logic                                        m_axis_tvalid,
    output logic                                        m_axis_tlast,
    output logic [tid_width(NUM_SRC)-1:0]               m_axis_tid,
    input  logic                                        m_axis_tready,
    output logic                                        busy_o,
    output logic [tid_width(NUM_SRC)-1:0]               grant_o,
    output logic [31:0]                                 beat_cnt_o
);

    localparam int BW = beat_width(COORD_WIDTH);
    localparam int TW = tid_width(NUM_SRC);

    arb_state_t    state_q, state_d;
    logic [TW-1:0] grant_q, grant_d;
    logic [TW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0] win_idx;
    logic          win_found;
    logic          skid_in_valid;
    logic          skid_in_ready;
    logic          skid_out_valid;
    logic          skid_empty;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        int            idx;
        logic [TW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx  = (int'(rr_ptr_q) + k) % NUM_SRC;
            cand = TW'(idx);
            if (!win_found && s_axis_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbiter next state, grant latch and per-source ready steering.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        skid_in_valid = 1'b0;
        s_axis_tready = '0;
        unique case (state_q)
            IDLE: begin
                if (enable_i && win_found) begin
                    state_d  = LOCKED;
                    grant_d  = win_idx;
                    rr_ptr_d = win_idx;
                end
            end
            LOCKED: begin
                skid_in_valid          = s_axis_tvalid[grant_q];
                s_axis_tready[grant_q] = skid_in_ready & ~rst;
                if (skid_in_valid && skid_in_ready && s_axis_tlast[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state register; pointer resets to the last source so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= TW'(NUM_SRC - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    vec_mag_axis_skid #(
        .DW (BW),
        .TW (TW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s_axis_tdata[grant_q]),
        .in_last   (s_axis_tlast[grant_q]),
        .in_tid    (grant_q),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (m_axis_tdata),
        .out_last  (m_axis_tlast),
        .out_tid   (m_axis_tid),
        .out_valid (skid_out_valid),
        .out_ready (m_axis_tready),
        .empty     (skid_empty)
    );

    assign m_axis_tvalid = skid_out_valid & ~rst;
    assign busy_o        = (state_q == LOCKED) | ~skid_empty;
    assign grant_o       = grant_q;

    // Count master-side handshakes, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_o <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            beat_cnt_o <= beat_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_vec_mag_stream_arb.sv
// Directed and randomized checks of vec_mag_stream_arb against a packet-level
// round-robin reference model.
module tb_vec_mag_stream_arb;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int BW = 32;
    localparam int TW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable_i;
    logic [N-1:0][BW-1:0] s_tdata;
    logic [N-1:0]         s_tvalid;
    logic [N-1:0]         s_tlast;
    logic [N-1:0]         s_tready;
    logic [BW-1:0]        m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic [TW-1:0]        m_tid;
    logic                 m_tready;
    logic                 busy;
    logic [TW-1:0]        grant;
    logic [31:0]          beat_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vec_mag_stream_arb #(.NUM_SRC(N), .COORD_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tready (m_tready),
        .busy_o        (busy),
        .grant_o       (grant),
        .beat_cnt_o    (beat_cnt)
    );

    logic [BW-1:0] drv_d [N][$];
    bit            drv_l [N][$];
    bit            hold  [N];
    int            src_acc [N];
    logic [BW-1:0] md [N][$];
    bit            ml [N][$];
    int            mp [N];
    int            mptr;
    int            model_cnt;
    logic [BW-1:0] exp_d [$];
    bit            exp_l [$];
    int            exp_t [$];
    logic [BW-1:0] obs_d [$];
    bit            obs_l [$];
    int            obs_t [$];
    int            obs_c [$];
    bit            bp_pat [$];
    bit            bp_rand;
    int            cyc;
    bit            st_pend;
    logic [BW-1:0] st_d;
    logic          st_l;
    logic [TW-1:0] st_t;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (drv_d[i].size() != 0) p = 1;
        return p;
    endfunction

    task automatic add_beat(input int s, input logic [BW-1:0] d, input bit l);
        drv_d[s].push_back(d);
        drv_l[s].push_back(l);
        md[s].push_back(d);
        ml[s].push_back(l);
        if (l) mp[s]++;
    endtask

    task automatic add_pkt(input int s, input int n);
        for (int b = 0; b < n; b++) add_beat(s, $urandom, b == n - 1);
    endtask

    // Packet-level round robin: next pending source after the last one served.
    task automatic build_expected();
        int total;
        int s;
        int c;
        bit l;
        total = 0;
        for (int i = 0; i < N; i++) total += mp[i];
        while (total > 0) begin
            s = -1;
            for (int k = 1; k <= N; k++) begin
                c = (mptr + k) % N;
                if (s < 0 && mp[c] > 0) s = c;
            end
            l = 0;
            while (!l) begin
                exp_d.push_back(md[s].pop_front());
                l = ml[s].pop_front();
                exp_l.push_back(l);
                exp_t.push_back(s);
            end
            mp[s]--;
            total--;
            mptr = s;
        end
    endtask

    task automatic step();
        logic [N-1:0]  acc;
        bit            mf;
        logic [BW-1:0] fd;
        bit            fl;
        int            ft;
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = !hold[i] && drv_d[i].size() != 0;
            s_tdata[i]  = drv_d[i].size() != 0 ? drv_d[i][0] : '0;
            s_tlast[i]  = drv_l[i].size() != 0 ? drv_l[i][0] : 1'b0;
        end
        if (m_tvalid && bp_pat.size() != 0) m_tready = bp_pat.pop_front();
        else if (bp_rand) m_tready = 1'($urandom_range(0, 1));
        else m_tready = 1'b1;
        #1;
        if (st_pend) begin
            chk("stall_valid", 64'(m_tvalid), 64'd1);
            chk("stall_beat", {m_tlast, m_tid, m_tdata}, {st_l, st_t, st_d});
        end
        chk("tready_onehot", 64'($countones(s_tready) <= 1), 64'd1);
        if (rst) begin
            chk("rst_tready", 64'(s_tready), 64'd0);
            chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        end
        st_pend = m_tvalid && !m_tready;
        st_d = m_tdata;
        st_l = m_tlast;
        st_t = m_tid;
        acc = rst ? '0 : (s_tvalid & s_tready);
        mf = !rst && m_tvalid && m_tready;
        fd = m_tdata;
        fl = m_tlast;
        ft = int'(m_tid);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(drv_d[i].pop_front());
                void'(drv_l[i].pop_front());
                src_acc[i]++;
            end
        end
        if (mf) begin
            obs_d.push_back(fd);
            obs_l.push_back(fl);
            obs_t.push_back(ft);
            obs_c.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic run(input int budget, input string tag);
        int n = 0;
        while ((busy || pending()) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 64'(busy || pending()), 64'd0);
    endtask

    task automatic wait_acc(input int s, input int k, input string tag);
        int n = 0;
        while (src_acc[s] < k && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_acc_timeout"}, 64'(src_acc[s] >= k), 64'd1);
    endtask

    task automatic compare(input string tag);
        build_expected();
        chk({tag, "_count"}, 64'(obs_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            chk({tag, "_beat"}, {obs_l[i], 2'(obs_t[i]), obs_d[i]},
                {exp_l[i], 2'(exp_t[i]), exp_d[i]});
        end
        model_cnt += exp_d.size();
        chk({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(model_cnt));
        exp_d.delete(); exp_l.delete(); exp_t.delete();
        obs_d.delete(); obs_l.delete(); obs_t.delete(); obs_c.delete();
        for (int i = 0; i < N; i++) src_acc[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            drv_d[i].delete(); drv_l[i].delete();
            md[i].delete(); ml[i].delete();
            mp[i] = 0; hold[i] = 0; src_acc[i] = 0;
        end
        obs_d.delete(); obs_l.delete(); obs_t.delete(); obs_c.delete();
        exp_d.delete(); exp_l.delete(); exp_t.delete();
        mptr = N - 1;
        model_cnt = 0;
        st_pend = 0;
        chk("post_rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("post_rst_tready", 64'(s_tready), 64'd0);
        chk("post_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("post_rst_grant", 64'(grant), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int c0;
        int n;
        rst = 1'b1;
        enable_i = 1'b1;
        s_tdata = '0;
        s_tvalid = '0;
        s_tlast = '0;
        m_tready = 1'b1;
        bp_rand = 0;
        cyc = 0;
        st_pend = 0;
        mptr = N - 1;
        model_cnt = 0;
        for (int i = 0; i < N; i++) begin
            hold[i] = 0; mp[i] = 0; src_acc[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single packet from source 2 with exact latency
        c0 = cyc;
        add_beat(2, 32'h01020304, 0);
        add_beat(2, 32'h05060708, 0);
        add_beat(2, 32'h090A0B0C, 1);
        run(50, "single");
        if (obs_c.size() == 3) begin
            chk("single_first_lat", 64'(obs_c[0] - c0), 64'd2);
            chk("single_last_lat", 64'(obs_c[2] - c0), 64'd4);
        end
        chk("single_grant", 64'(grant), 64'd2);
        compare("single");

        // Fairness from reset: all four sources pending
        do_reset();
        for (int s = 0; s < N; s++) add_pkt(s, 2);
        run(100, "fair");
        compare("fair");

        // Backpressure during a 4-beat packet
        bp_pat.push_back(1); bp_pat.push_back(0);
        bp_pat.push_back(0); bp_pat.push_back(1);
        add_pkt(0, 4);
        run(50, "bp");
        compare("bp");

        // Granted source stalls while another is waiting
        add_pkt(1, 3);
        add_pkt(0, 2);
        wait_acc(1, 1, "stall");
        hold[1] = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_grant", 64'(grant), 64'd1);
            chk("stall_src0_ready", 64'(s_tready[0]), 64'd0);
        end
        hold[1] = 0;
        run(60, "stall");
        compare("stall");

        // Enable drops mid-packet; pending source waits for re-enable
        add_pkt(1, 3);
        wait_acc(1, 1, "en");
        enable_i = 1'b0;
        add_pkt(3, 2);
        n = 0;
        while ((drv_d[1].size() != 0 || busy) && n < 50) begin
            step();
            n++;
        end
        chk("en_drain_timeout", 64'(drv_d[1].size() != 0 || busy), 64'd0);
        repeat (6) step();
        chk("en_no_grant_acc", 64'(src_acc[3]), 64'd0);
        chk("en_no_grant_busy", 64'(busy), 64'd0);
        chk("en_grant_hold", 64'(grant), 64'd1);
        enable_i = 1'b1;
        run(50, "en");
        compare("en");

        // Reset in the middle of a packet
        add_pkt(0, 4);
        wait_acc(0, 2, "rstmid");
        do_reset();
        add_pkt(1, 2);
        add_pkt(0, 2);
        run(60, "rstmid");
        compare("rstmid");

        // Randomized rounds with random backpressure
        bp_rand = 1;
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < N; s++) begin
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                    add_pkt(s, int'($urandom_range(1, 4)));
                end
            end
            run(600, "rand");
            compare("rand");
        end
        bp_rand = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
